// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, opcode field, HALT/NOP encodings,
// and the fetch/decode buffer entry.
package cpu_types_pkg;

  localparam int WORD_W   = 32;
  localparam int OPCODE_W = 6;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t HALT     = 6'b111111;
  localparam word_t   NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    word_t instr;
    word_t npc;
  } ifid_entry_t;

  function automatic logic is_halt(input word_t w);
    return w[WORD_W-1 -: OPCODE_W] == HALT;
  endfunction

endpackage

// File: rtl/ifid_if.sv
// Fetch/decode boundary bundle around ifid_buffer; fetch side sees the icache
// return and the throttles, decode side sees the head entry and drives stall/flush.
interface ifid_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  word_t nPC;
  logic  stall;
  logic  flush;
  logic  imemREN;
  logic  pc_en;
  word_t instr_out;
  word_t npc_out;
  logic  valid_out;
  logic  halted;

  modport fetch (
    output ihit, imemload, nPC,
    input  imemREN, pc_en, halted
  );

  modport decode (
    input  instr_out, npc_out, valid_out, halted,
    output stall, flush
  );

endinterface

// File: rtl/ifid_buffer.sv
// Fetch-to-decode 2-entry in-order queue; captures accepted fetches, throttles the PC,
// absorbs decode stalls, drops wrong-path work on flush and stops fetch after HALT.
module ifid_buffer
  import cpu_types_pkg::*;
#(
  parameter int    DEPTH = 2,
  parameter word_t NOP   = NOP_WORD
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  input  word_t nPC,
  input  logic  stall,
  input  logic  flush,
  output logic  imemREN,
  output logic  pc_en,
  output word_t instr_out,
  output word_t npc_out,
  output logic  valid_out,
  output logic  halted
);

  // Pointers are a single bit, so only DEPTH == 2 is meaningful.
  ifid_entry_t entry_q [DEPTH];
  logic [1:0]  count;
  logic        head;
  logic        tail;

  logic full;
  logic accept;
  logic pop;

  // Accept looks only at registered occupancy so stall never reaches pc_en.
  assign full      = (count == 2'd2);
  assign accept    = ihit & ~full & ~halted & ~flush;
  assign valid_out = (count != 2'd0);
  assign pop       = valid_out & ~stall;

  assign pc_en     = accept;
  assign imemREN   = ~full & ~halted;
  assign instr_out = valid_out ? entry_q[head].instr : NOP;
  assign npc_out   = valid_out ? entry_q[head].npc   : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else if (flush) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (accept) tail <= ~tail;
      if (pop)    head <= ~head;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else if (accept) begin
      entry_q[tail] <= '{instr: imemload, npc: nPC};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halted <= 1'b0;
    end else if (flush) begin
      halted <= 1'b0;
    end else if (accept && is_halt(imemload)) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifid_buffer.sv
// Scoreboarded bench for ifid_buffer: directed scenarios then random traffic,
// checked each cycle against a queue-level reference model.
module tb_ifid_buffer;
  import cpu_types_pkg::*;

  logic clk;
  logic rst_n;
  ifid_if bus();

  ifid_buffer dut (
    .CLK       (clk),
    .nRST      (rst_n),
    .ihit      (bus.ihit),
    .imemload  (bus.imemload),
    .nPC       (bus.nPC),
    .stall     (bus.stall),
    .flush     (bus.flush),
    .imemREN   (bus.imemREN),
    .pc_en     (bus.pc_en),
    .instr_out (bus.instr_out),
    .npc_out   (bus.npc_out),
    .valid_out (bus.valid_out),
    .halted    (bus.halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: expected decode-side entries in arrival order.
  ifid_entry_t exp_q [$];
  logic        m_halted = 1'b0;
  int          n_popped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares outputs mid-cycle, then advances the model across the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic        m_full, m_valid, m_acc;
      ifid_entry_t head_e;
      m_full  = (exp_q.size() >= 2);
      m_valid = (exp_q.size() != 0);
      m_acc   = bus.ihit && !m_full && !m_halted && !bus.flush;
      head_e  = m_valid ? exp_q[0] : '0;
      chk("valid_out", {31'd0, bus.valid_out}, {31'd0, m_valid});
      chk("imemREN",   {31'd0, bus.imemREN},   {31'd0, !m_full && !m_halted});
      chk("pc_en",     {31'd0, bus.pc_en},     {31'd0, m_acc});
      chk("halted",    {31'd0, bus.halted},    {31'd0, m_halted});
      if (m_valid) begin
        chk("instr_out", bus.instr_out, head_e.instr);
        chk("npc_out",   bus.npc_out,   head_e.npc);
      end else begin
        chk("instr_nop", bus.instr_out, NOP_WORD);
        chk("npc_zero",  bus.npc_out,   32'd0);
      end
      if (bus.flush) begin
        exp_q.delete();
        m_halted = 1'b0;
      end else begin
        if (m_valid && !bus.stall) begin
          void'(exp_q.pop_front());
          n_popped++;
        end
        if (m_acc) begin
          exp_q.push_back('{instr: bus.imemload, npc: bus.nPC});
          if (bus.imemload[31:26] == 6'b111111) m_halted = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic ih, input word_t w, input word_t npc,
                       input logic st, input logic fl);
    bus.ihit     = ih;
    bus.imemload = w;
    bus.nPC      = npc;
    bus.stall    = st;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic fill_two(input word_t base);
    drive(1'b1, base,         32'h100, 1'b1, 1'b0);
    drive(1'b1, base + 32'd1, 32'h104, 1'b1, 1'b0);
  endtask

  initial begin
    bus.ihit = 0; bus.imemload = 0; bus.nPC = 0; bus.stall = 0; bus.flush = 0;
    rst_n = 1'b0;
    #3;
    chk("rst_valid",  {31'd0, bus.valid_out}, 32'd0);
    chk("rst_instr",  bus.instr_out,          NOP_WORD);
    chk("rst_npc",    bus.npc_out,            32'd0);
    chk("rst_ren",    {31'd0, bus.imemREN},   32'd1);
    chk("rst_pc_en",  {31'd0, bus.pc_en},     32'd0);
    chk("rst_halted", {31'd0, bus.halted},    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Streaming
    for (int i = 0; i < 8; i++)
      drive(1'b1, 32'h2001_0001 + 32'h0001_0001 * i, 32'd4 * (i + 1), 1'b0, 1'b0);
    idle(2);

    // Stall fill then drain
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h3000_0000 + i, 32'h200 + 4 * i, 1'b1, 1'b0);
    idle(3);

    // Flush with a simultaneous wrong-path fetch
    fill_two(32'h4000_0000);
    drive(1'b1, 32'hDEAD_BEEF, 32'h300, 1'b1, 1'b1);
    chk("flush_empty", {31'd0, bus.valid_out}, 32'd0);
    idle(2);

    // Halt, ignored fetches, drain, then flush clears halted
    drive(1'b1, 32'hFFFF_FFFF, 32'h400, 1'b1, 1'b0);
    chk("halt_set", {31'd0, bus.halted}, 32'd1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h5000_0000 + i, 32'h404, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("halt_clr", {31'd0, bus.halted}, 32'd0);

    // Full + pop race, then retry
    fill_two(32'h6000_0000);
    drive(1'b1, 32'h6000_0010, 32'h500, 1'b0, 1'b0);
    drive(1'b1, 32'h6000_0010, 32'h500, 1'b0, 1'b0);
    idle(3);

    // Async reset between edges with the queue full
    fill_two(32'h7000_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  {31'd0, bus.valid_out}, 32'd0);
    chk("arst_instr",  bus.instr_out,          32'd0);
    chk("arst_halted", {31'd0, bus.halted},    32'd0);
    exp_q.delete();
    m_halted = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      word_t w;
      w = $urandom;
      if ($urandom_range(0, 40) == 0) w[31:26] = 6'b111111;
      drive($urandom_range(0, 3) != 0, w, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    idle(3);

    n_total++;
    if (n_popped > 100) n_pass++;
    else $display("FAIL pop_activity: got %0d expected >100", n_popped);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
